ram_bram_responder: RTL and testbench
=====================================

RAM_BRAM_RESPONDER -- requirements
Module: ram_bram_responder

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16 to 65536.
- READ_LATENCY, 4, cycles from read acceptance to valid data; legal range 2 to 15.
- WRITE_LATENCY, 2, busy cycles after write acceptance; legal range 1 to 15.
- CALIB_CYCLES, 16, cycles after reset before calibration completes; legal range 1 to 65535.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  responder enable.
- addr_in  in  29  byte address; bits [1:0] ignored.
- write_data_in  in  32  write data.
- read_req  in  1  read request level.
- write_req  in  1  write request level.
- read_data_valid  out  1  one-cycle read-data strobe.
- read_data_out  out  32  read data.
- write_ready  out  1  write acceptable this cycle.
- read_ready  out  1  read acceptable this cycle.
- please_stall_everything  out  1  initiator must hold off.
- init_calib_complete  out  1  calibration done.
- oob_err  out  1  one-cycle out-of-range strobe.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have states CALIB, IDLE, WR_BUSY and RD_BUSY.
REQ-005 In CALIB, a counter SHALL count CALIB_CYCLES cycles, then the FSM SHALL enter IDLE and assert init_calib_complete, which SHALL stay high until reset.
REQ-006 In CALIB and in WR_BUSY/RD_BUSY, please_stall_everything SHALL be 1; in IDLE it SHALL be 0.
REQ-007 write_ready and read_ready SHALL each equal (state==IDLE) & en.
REQ-008 A request SHALL be accepted at a rising edge where state==IDLE, en=1 and read_req or write_req is 1; inputs SHALL be sampled only at that edge.
REQ-009 If read_req and write_req are both 1 at acceptance, the write SHALL win and the read SHALL be dropped silently.
REQ-010 Word index SHALL be addr_in[28:2]; an index >= DEPTH_WORDS SHALL be out of range.
REQ-011 For an accepted in-range write, the memory SHALL be updated at the acceptance edge, and the FSM SHALL spend WRITE_LATENCY cycles in WR_BUSY before returning to IDLE.
REQ-012 For an accepted read, the FSM SHALL spend READ_LATENCY cycles in RD_BUSY, and read_data_valid SHALL be 1 only in the last RD_BUSY cycle.
REQ-013 read_data_out SHALL carry the word read at the acceptance edge, or 32'h0 if out of range, and SHALL hold its last value otherwise.
REQ-014 An out-of-range write SHALL leave memory unchanged but still take the full WR_BUSY time.
REQ-015 oob_err SHALL pulse for one cycle, the cycle after acceptance, for any out-of-range access.
REQ-016 A request held across the return to IDLE SHALL be accepted again, since there is no edge detection.
REQ-017 If en drops while busy, the current operation SHALL still complete.

Reset
REQ-018 rst=1 at any edge SHALL force CALIB with the counter cleared.
REQ-019 Reset SHALL clear the outputs: read_data_valid=0, read_data_out=0, init_calib_complete=0, oob_err=0, please_stall_everything=1, write_ready=0 and read_ready=0.
REQ-020 Reset SHALL not clear memory contents.
REQ-021 Reset during WR_BUSY/RD_BUSY SHALL abort the operation with no read_data_valid; a write already committed at its acceptance edge SHALL remain.

Structure
REQ-022 Package ram_pkg SHALL hold the state enum, the default latency/depth/calibration constants and the out-of-range read value.
REQ-023 Storage SHALL be a sub-module ram_bram_array: a single-port, synchronous-read, write-first 32-bit memory of DEPTH_WORDS words.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then wait: init_calib_complete rises exactly 16 cycles after rst falls, and please_stall_everything falls in the same cycle.
- Write 32'hDEADBEEF to addresses 0,4,...,1020, then read them back: every read_data_valid returns 32'hDEADBEEF, 4 cycles after acceptance.
- Write to 29'h1000_0000: oob_err pulses, memory is unchanged, and a read of that address returns 32'h0 with oob_err.
- read_req=write_req=1 at address 8 with data 32'h1234_5678: only the write occurs, no read_data_valid, and a later read of address 8 returns 32'h1234_5678.
- Assert rst in the 2nd RD_BUSY cycle: no read_data_valid, state returns to CALIB, and after calibration the earlier data still reads back.
- en=0 with requests held: nothing is accepted and ready=0; on en=1 the request is accepted at the next edge.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: state encoding, default parameters and out-of-range read value for the BRAM responder
package ram_pkg;
  typedef enum logic [1:0] {CALIB, IDLE, WR_BUSY, RD_BUSY} state_t;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_READ_LATENCY = 4;
  localparam int DEF_WRITE_LATENCY = 2;
  localparam int DEF_CALIB_CYCLES = 16;
  localparam logic [31:0] OOB_READ_VALUE = 32'h0;
  function automatic logic is_oob(input logic [26:0] idx, input int depth);
    return {5'd0, idx} >= $unsigned(depth);
  endfunction
endpackage

// File: rtl/ram_bram_array.sv
// ram_bram_array: single-port synchronous-read write-first 32-bit memory
module ram_bram_array
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= we ? wdata : mem[addr];
    end
endmodule

// File: rtl/ram_bram_responder.sv
// ram_bram_responder: calibrating BRAM-backed responder with fixed read/write latencies
module ram_bram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter int CALIB_CYCLES = DEF_CALIB_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [28:0] addr_in,
  input  logic [31:0] write_data_in,
  input  logic        read_req,
  input  logic        write_req,
  output logic        read_data_valid,
  output logic [31:0] read_data_out,
  output logic        write_ready,
  output logic        read_ready,
  output logic        please_stall_everything,
  output logic        init_calib_complete,
  output logic        oob_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);
  localparam logic [15:0] RD_LAST = 16'(READ_LATENCY - 1);
  localparam logic [15:0] RD_PRE = 16'(READ_LATENCY - 2);
  localparam logic [15:0] WR_LAST = 16'(WRITE_LATENCY - 1);
  state_t state, state_next;
  logic [15:0] cnt;
  logic accept, oob, acc_oob, rd_fire;
  logic [31:0] rdata;
  assign accept = state == IDLE && en && (read_req || write_req);
  assign oob = is_oob(addr_in[28:2], DEPTH_WORDS);
  assign rd_fire = state == RD_BUSY && cnt == RD_PRE;
  ram_bram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk),
    .en(accept),
    .we(accept && write_req && !oob),
    .addr(addr_in[AW+1:2]),
    .wdata(write_data_in),
    .rdata(rdata)
  );
  always_ff @(posedge clk) state <= rst ? CALIB : state_next;
  always_comb begin
    state_next = state;
    case (state)
      CALIB:   state_next = cnt == CALIB_LAST ? IDLE : CALIB;
      IDLE:    state_next = !accept ? IDLE : write_req ? WR_BUSY : RD_BUSY;
      WR_BUSY: state_next = cnt == WR_LAST ? IDLE : WR_BUSY;
      RD_BUSY: state_next = cnt == RD_LAST ? IDLE : RD_BUSY;
      default: state_next = CALIB;
    endcase
  end
  always_comb begin
    please_stall_everything = state != IDLE;
    write_ready = state == IDLE && en;
    read_ready = state == IDLE && en;
    init_calib_complete = state != CALIB;
  end
  // read data is registered one cycle early so valid and data land together in the last busy cycle
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      read_data_valid <= 1'b0;
      read_data_out <= '0;
      oob_err <= 1'b0;
      acc_oob <= 1'b0;
    end else begin
      cnt <= (state_next != state || state == IDLE) ? 16'd0 : cnt + 16'd1;
      oob_err <= accept && oob;
      if (accept) acc_oob <= oob;
      read_data_valid <= rd_fire;
      if (rd_fire) read_data_out <= acc_oob ? OOB_READ_VALUE : rdata;
    end
endmodule

// File: tb/tb_ram_bram_responder.sv
// tb_ram_bram_responder: scoreboard bench with a word-array reference model of the responder
module tb_ram_bram_responder;
  localparam int DEPTH = 1024;
  localparam int RL = 4;
  localparam int WL = 2;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, read_req = 1'b0, write_req = 1'b0;
  logic [28:0] addr_in = '0;
  logic [31:0] write_data_in = '0;
  logic read_data_valid, write_ready, read_ready, please_stall_everything, init_calib_complete, oob_err;
  logic [31:0] read_data_out;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  logic [31:0] mem_m [DEPTH];
  bit known [DEPTH];
  int cyc = 0, total = 0, passed = 0;
  ram_bram_responder dut (
    .clk(clk), .rst(rst), .en(en), .addr_in(addr_in), .write_data_in(write_data_in),
    .read_req(read_req), .write_req(write_req), .read_data_valid(read_data_valid),
    .read_data_out(read_data_out), .write_ready(write_ready), .read_ready(read_ready),
    .please_stall_everything(please_stall_everything), .init_calib_complete(init_calib_complete),
    .oob_err(oob_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
  endfunction
  function automatic void chkb(string n, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", n, act, exp, cyc);
  endfunction
  // every read_data_valid must match the oldest outstanding read, in value and in cycle
  always @(negedge clk)
    if (read_data_valid) begin
      if (q.size() == 0) chkb("unexpected_valid", read_data_valid, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", read_data_out, e.d);
        chk("rd_latency", cyc, e.c);
      end
    end
  task automatic calib_wait();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chkb("calib_done", init_calib_complete, k == 16);
      chkb("calib_stall", please_stall_everything, k != 16);
    end
  endtask
  task automatic op(input bit wr, input bit rd, input logic [28:0] a, input logic [31:0] d);
    int idx, accn;
    bit o;
    en = 1'b1;
    #1;
    chkb("write_ready", write_ready, 1'b1);
    chkb("read_ready", read_ready, 1'b1);
    chkb("stall_idle", please_stall_everything, 1'b0);
    addr_in = a;
    write_data_in = d;
    write_req = wr;
    read_req = rd;
    accn = cyc;
    idx = int'(a[28:2]);
    o = idx >= DEPTH;
    @(posedge clk);
    @(negedge clk);
    write_req = 1'b0;
    read_req = 1'b0;
    en = 1'($urandom_range(0, 1));
    chkb("oob_err", oob_err, o);
    chkb("stall_busy", please_stall_everything, 1'b1);
    if (wr && !o) begin
      mem_m[idx] = d;
      known[idx] = 1'b1;
    end
    if (rd && !wr) q.push_back('{o ? 32'h0 : mem_m[idx % DEPTH], accn + RL});
    repeat (wr ? WL : RL) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chkb("rst_valid", read_data_valid, 1'b0);
    chk("rst_data", read_data_out, 32'h0);
    chkb("rst_calib", init_calib_complete, 1'b0);
    chkb("rst_oob", oob_err, 1'b0);
    chkb("rst_stall", please_stall_everything, 1'b1);
    chkb("rst_wready", write_ready, 1'b0);
    chkb("rst_rready", read_ready, 1'b0);
    calib_wait();
    for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 29'(i * 4), 32'hDEADBEEF);
    for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 29'(i * 4), 32'h0);
    op(1'b1, 1'b0, 29'h1000_0000, 32'h5555_AAAA);
    op(1'b0, 1'b1, 29'd0, 32'h0);
    op(1'b0, 1'b1, 29'h1000_0000, 32'h0);
    op(1'b1, 1'b1, 29'd8, 32'h1234_5678);
    op(1'b0, 1'b1, 29'd8, 32'h0);
    en = 1'b0;
    write_req = 1'b1;
    addr_in = 29'd40;
    write_data_in = 32'hA5A5_0001;
    repeat (3) begin
      @(negedge clk);
      chkb("en0_wready", write_ready, 1'b0);
      chkb("en0_rready", read_ready, 1'b0);
      chkb("en0_no_accept", please_stall_everything, 1'b0);
    end
    op(1'b1, 1'b0, 29'd40, 32'hA5A5_0001);
    op(1'b0, 1'b1, 29'd40, 32'h0);
    for (int i = 0; i < 150; i++) begin
      int k, w;
      k = int'($urandom_range(0, 9));
      w = int'($urandom_range(0, DEPTH - 1));
      if (k == 0) op(1'b1, 1'b0, 29'h0800_0000 | 29'($urandom_range(0, 1023) * 4), $urandom);
      else if (k == 1) op(1'b0, 1'b1, 29'h0400_0000 | 29'(w * 4), 32'h0);
      else if (k == 2) op(1'b1, 1'b1, 29'(w * 4), $urandom);
      else if (k < 6) op(1'b1, 1'b0, 29'(w * 4), $urandom);
      else op(1'b0, 1'b1, 29'((known[w] ? w : w % 256) * 4), 32'h0);
    end
    op(1'b1, 1'b0, 29'd12, 32'hCAFE_F00D);
    en = 1'b1;
    addr_in = 29'd12;
    read_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chkb("abort_valid", read_data_valid, 1'b0);
    chkb("abort_calib", init_calib_complete, 1'b0);
    chkb("abort_stall", please_stall_everything, 1'b1);
    chkb("abort_ready", read_ready, 1'b0);
    chk("abort_data", read_data_out, 32'h0);
    calib_wait();
    op(1'b0, 1'b1, 29'd12, 32'h0);
    op(1'b0, 1'b1, 29'd40, 32'h0);
    op(1'b0, 1'b1, 29'd0, 32'h0);
    repeat (10) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
